// File: rtl/uart_peripheral.sv
// 8N1 UART endpoint for the peripheral hub: one transmitter, one receiver, shared baud divider.
// Latency: tx goes low the cycle after a send_tx rising edge; ready rises one cycle after the stop-bit sample.
// Backpressure: send_tx edges seen while busy are dropped; an unread byte is overwritten on overrun.
module uart_peripheral #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send_tx,
    input  logic [7:0] tx_data,
    input  logic       clear_ready,
    input  logic       rx,
    output logic       tx,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       ready
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          tx_state;
    logic [CW-1:0]   tx_cnt;
    logic [2:0]      tx_idx;
    logic [7:0]      tx_shift;
    logic            send_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state  <= IDLE;
            tx_cnt    <= '0;
            tx_idx    <= '0;
            tx_shift  <= '0;
            send_prev <= 1'b0;
            tx        <= 1'b1;
            busy      <= 1'b0;
        end else begin
            send_prev <= send_tx;
            case (tx_state)
                IDLE: begin
                    if (send_tx && !send_prev) begin
                        tx_shift <= tx_data;
                        tx_cnt   <= '0;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        tx_state <= START;
                    end
                end
                START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_idx   <= '0;
                        tx       <= tx_shift[0];
                        tx_state <= DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx == IDX_LAST) begin
                            tx       <= 1'b1;
                            tx_state <= STOP;
                        end else begin
                            // Present the next bit while shifting so tx stays a pure register.
                            tx_idx   <= tx_idx + 1'b1;
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx       <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        busy     <= 1'b0;
                        tx_state <= IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    logic rx_s1;
    logic rx_s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
        end
    end

    state_t          rx_state;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_idx;
    logic [7:0]      rx_shift;
    logic            rx_wait_high;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state     <= IDLE;
            rx_cnt       <= '0;
            rx_idx       <= '0;
            rx_shift     <= '0;
            rx_wait_high <= 1'b0;
            rx_data      <= '0;
            ready        <= 1'b0;
        end else begin
            if (clear_ready) begin
                ready <= 1'b0;
            end
            case (rx_state)
                IDLE: begin
                    // After a framing error the line must go idle before a new start bit counts.
                    if (rx_wait_high) begin
                        if (rx_s2) begin
                            rx_wait_high <= 1'b0;
                        end
                    end else if (!rx_s2) begin
                        rx_cnt   <= '0;
                        rx_state <= START;
                    end
                end
                START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_idx   <= '0;
                        rx_state <= rx_s2 ? IDLE : DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        if (rx_idx == IDX_LAST) begin
                            rx_state <= STOP;
                        end else begin
                            rx_idx <= rx_idx + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= IDLE;
                        // A completed byte overrides a same-cycle clear.
                        if (rx_s2) begin
                            rx_data <= rx_shift;
                            ready   <= 1'b1;
                        end else begin
                            rx_wait_high <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_peripheral.sv
// Randomised bench for uart_peripheral with a frame-level reference model and per-cycle output compare.
module tb_uart_peripheral;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       send_tx = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       clear_ready = 1'b0;
    logic       rx_drv = 1'b1;
    logic       loop = 1'b0;
    logic       rx_line;
    logic       tx;
    logic [7:0] rx_data;
    logic       busy;
    logic       ready;

    assign rx_line = loop ? tx : rx_drv;

    uart_peripheral #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .send_tx    (send_tx),
        .tx_data    (tx_data),
        .clear_ready(clear_ready),
        .rx         (rx_line),
        .tx         (tx),
        .rx_data    (rx_data),
        .busy       (busy),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a frame occupies 10*CPB cycles after the accepting edge;
    // a received byte lands on the edge after the last stop-bit cycle on the line.
    int         n = 0;
    bit         m_active = 1'b0;
    int         m_n0 = 0;
    logic [7:0] m_byte = 8'h00;
    logic       m_prev = 1'b0;
    logic       m_ready = 1'b0;
    logic [7:0] m_rx_data = 8'h00;
    int         m_frames = 0;
    int         rx_edge = -1;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_ok = 1'b0;
    int         lb_edge = -1;
    logic [7:0] lb_byte = 8'h00;
    int         busy_cnt = 0;

    always @(posedge clk) begin
        bit idle;
        n = n + 1;
        if (reset) begin
            m_active  = 1'b0;
            m_prev    = 1'b0;
            m_ready   = 1'b0;
            m_rx_data = 8'h00;
            lb_edge   = -1;
        end else begin
            idle = !m_active;
            if (m_active && (n - m_n0) >= 10 * CPB) m_active = 1'b0;
            if (idle && send_tx && !m_prev) begin
                m_active = 1'b1;
                m_n0     = n;
                m_byte   = tx_data;
                m_frames = m_frames + 1;
                if (loop) begin
                    lb_edge = n + 10 * CPB + 1;
                    lb_byte = tx_data;
                end
            end
            m_prev = send_tx;
            if (clear_ready) m_ready = 1'b0;
            if (n == rx_edge && rx_ok) begin
                m_ready   = 1'b1;
                m_rx_data = rx_byte;
            end
            if (n == lb_edge) begin
                m_ready   = 1'b1;
                m_rx_data = lb_byte;
            end
        end
    end

    always @(negedge clk) begin
        logic [9:0] fr;
        int         idx;
        logic       e_tx;
        logic       e_busy;
        if (reset || !m_active) begin
            e_tx   = 1'b1;
            e_busy = 1'b0;
        end else begin
            fr     = {1'b1, m_byte, 1'b0};
            idx    = (n - m_n0) / CPB;
            e_tx   = fr[idx[3:0]];
            e_busy = 1'b1;
        end
        chk("tx", 8'(tx), 8'(e_tx));
        chk("busy", 8'(busy), 8'(e_busy));
        chk("ready", 8'(ready), reset ? 8'h00 : 8'(m_ready));
        chk("rx_data", rx_data, reset ? 8'h00 : m_rx_data);
        if (busy) busy_cnt = busy_cnt + 1;
    end

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_send(input logic [7:0] b);
        send_tx = 1'b1;
        tx_data = b;
        step(1);
        send_tx = 1'b0;
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = f[i];
            step(CPB);
        end
        rx_drv  = 1'b1;
        rx_byte = b;
        rx_ok   = stop;
        rx_edge = n + 1;
    endtask

    initial begin
        logic [9:0] bits;
        int         b0;
        int         f0;
        logic [7:0] rb;
        logic [7:0] tb_byte;
        logic       rs;

        step(3);
        chk("reset_tx", 8'(tx), 8'h01);
        chk("reset_busy", 8'(busy), 8'h00);
        chk("reset_ready", 8'(ready), 8'h00);
        reset = 1'b0;
        step(2);

        // TX basic
        b0 = busy_cnt;
        pulse_send(8'hA5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bits[i] = tx;
            repeat (CPB - 1) @(negedge clk);
        end
        step(5);
        chk("a5_bits", bits[7:0], 8'h4A);
        chk("a5_bits_hi", 8'(bits[9:8]), 8'h03);
        chk("a5_busy_len", 8'(busy_cnt - b0), 8'd40);
        chk("a5_idle_tx", 8'(tx), 8'h01);

        // TX held level plus an ignored edge while busy
        b0 = busy_cnt;
        f0 = m_frames;
        send_tx = 1'b1;
        tx_data = 8'h3C;
        step(9);
        send_tx = 1'b0;
        step(1);
        send_tx = 1'b1;
        tx_data = 8'hFF;
        step(50);
        send_tx = 1'b0;
        step(10);
        chk("level_frames", 8'(m_frames - f0), 8'd1);
        chk("level_busy_len", 8'(busy_cnt - b0), 8'd40);

        // RX basic and clear
        rx_frame(8'h5A, 1'b1);
        step(2);
        chk("rx5a_ready", 8'(ready), 8'h01);
        chk("rx5a_data", rx_data, 8'h5A);
        clear_ready = 1'b1;
        step(1);
        clear_ready = 1'b0;
        chk("clr_ready", 8'(ready), 8'h00);
        chk("clr_data", rx_data, 8'h5A);

        // RX glitch and framing error
        rx_drv = 1'b0;
        step(1);
        rx_drv = 1'b1;
        step(20);
        chk("glitch_ready", 8'(ready), 8'h00);
        rx_frame(8'h81, 1'b0);
        step(12);
        chk("ferr_ready", 8'(ready), 8'h00);
        chk("ferr_data", rx_data, 8'h5A);
        rx_frame(8'h42, 1'b1);
        step(2);
        chk("rx42_data", rx_data, 8'h42);
        chk("rx42_ready", 8'(ready), 8'h01);
        clear_ready = 1'b1;
        step(1);
        clear_ready = 1'b0;
        step(4);

        // Set/clear collision, then overrun
        rx_frame(8'h11, 1'b1);
        clear_ready = 1'b1;
        step(1);
        clear_ready = 1'b0;
        step(2);
        chk("coll_ready", 8'(ready), 8'h01);
        chk("coll_data", rx_data, 8'h11);
        rx_frame(8'h22, 1'b1);
        step(2);
        chk("ovr_ready", 8'(ready), 8'h01);
        chk("ovr_data", rx_data, 8'h22);

        // Random concurrent TX and RX traffic
        for (int it = 0; it < 8; it++) begin
            tb_byte = 8'($urandom);
            rb      = 8'($urandom);
            rs      = ($urandom_range(0, 3) != 0);
            fork
                begin
                    step($urandom_range(0, 4));
                    pulse_send(tb_byte);
                    step(44);
                end
                begin
                    step($urandom_range(0, 3));
                    rx_frame(rb, rs);
                    step(CPB + 2);
                    if ($urandom_range(0, 1) == 1) begin
                        clear_ready = 1'b1;
                        step(1);
                        clear_ready = 1'b0;
                    end
                end
            join
            step(2);
        end

        // Reset mid-frame, then loopback
        pulse_send(8'hF0);
        step(15);
        reset = 1'b1;
        #1;
        chk("rst_tx", 8'(tx), 8'h01);
        chk("rst_busy", 8'(busy), 8'h00);
        step(3);
        reset = 1'b0;
        step(1);
        chk("rst_ready", 8'(ready), 8'h00);
        chk("rst_data", rx_data, 8'h00);
        step(10);
        chk("post_rst_tx", 8'(tx), 8'h01);
        loop = 1'b1;
        step(3);
        pulse_send(8'hC3);
        step(50);
        chk("lb_ready", 8'(ready), 8'h01);
        chk("lb_data", rx_data, 8'hC3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
